// File: rtl/ssp_pkg.sv
// Shared types and sizes for the SSP host-side controller and its helpers.
package ssp_pkg;

    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        READ_CAP
    } ssp_state_e;

endpackage

// File: rtl/ssp_drain_timer.sv
// Saturating idle counter with synchronous clear; flags expiry once DRAIN_CYCLES
// qualifying cycles have elapsed, holding the flag until cleared.
module ssp_drain_timer #(
    parameter int DRAIN_CYCLES = 48
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int                CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DRAIN_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The cycle that completes the count already reports expiry, so the read
    // decision lands on the DRAIN_CYCLES-th qualifying idle cycle.
    assign o_expired = (r_count == LIMIT) ||
                       (i_count && (r_count == (LIMIT - 1'b1)));

endmodule

// File: rtl/ssp_host_ctrl.sv
// Host controller driving the SSP processor bus from a byte producer/consumer pair.
// Optional SSP_HOST_STATS_EN adds tx_count/rx_count completion counters.
module ssp_host_ctrl
    import ssp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = SSP_FIFO_DEPTH,
    parameter int DRAIN_CYCLES    = 48
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  src_valid,
    input  logic [SSP_DATA_W-1:0] src_data,
    output logic                  src_ready,
    output logic                  dst_valid,
    output logic [SSP_DATA_W-1:0] dst_data,
    input  logic                  dst_ready,
    output logic                  PSEL,
    output logic                  PWRITE,
    output logic [SSP_DATA_W-1:0] PWDATA,
    input  logic [SSP_DATA_W-1:0] PRDATA,
    input  logic                  SSPTXINTR,
    input  logic                  SSPRXINTR,
    input  logic                  SSPOE_B
`ifdef SSP_HOST_STATS_EN
    ,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count
`endif
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    ssp_state_e            r_state;
    logic [OUT_W-1:0]      r_outstanding;
    logic                  r_psel;
    logic                  r_pwrite;
    logic [SSP_DATA_W-1:0] r_pwdata;
    logic                  r_dst_valid;
    logic [SSP_DATA_W-1:0] r_dst_data;

    logic w_idle;
    logic w_have_out;
    logic w_slot_free;
    logic w_expired;
    logic w_do_read;
    logic w_do_write;
    logic w_timer_clear;
    logic w_timer_count;

    // Reads are gated on outstanding>0 so the loopback byte count can never underflow.
    assign w_idle      = (r_state == IDLE);
    assign w_have_out  = (r_outstanding != '0);
    assign w_slot_free = !r_dst_valid || dst_ready;
    assign w_do_read   = w_idle && w_slot_free && w_have_out && (SSPRXINTR || w_expired);
    assign w_do_write  = w_idle && !w_do_read && src_valid && !SSPTXINTR &&
                         (r_outstanding < OUT_MAX);

    assign w_timer_clear = (r_state == WRITE) || (r_state == READ) || !w_have_out;
    assign w_timer_count = w_idle && w_have_out && SSPOE_B;

    ssp_drain_timer #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain_timer (
        .i_clk     (PCLK),
        .i_rst_n   (CLEAR_B),
        .i_clear   (w_timer_clear),
        .i_count   (w_timer_count),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_state       <= IDLE;
            r_outstanding <= '0;
            r_psel        <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_dst_valid   <= 1'b0;
            r_dst_data    <= '0;
        end else begin
            if (r_dst_valid && dst_ready) begin
                r_dst_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_do_read) begin
                        r_state  <= READ;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b0;
                    end else if (w_do_write) begin
                        r_state  <= WRITE;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                        r_pwdata <= src_data;
                    end
                end
                WRITE: begin
                    r_state       <= IDLE;
                    r_psel        <= 1'b0;
                    r_pwrite      <= 1'b0;
                    r_outstanding <= r_outstanding + 1'b1;
                end
                READ: begin
                    r_state <= READ_CAP;
                    r_psel  <= 1'b0;
                end
                READ_CAP: begin
                    r_state       <= IDLE;
                    r_dst_data    <= PRDATA;
                    r_dst_valid   <= 1'b1;
                    r_outstanding <= r_outstanding - 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_psel  <= 1'b0;
                end
            endcase
        end
    end

    // src_ready is a same-cycle handshake; it is forced low while reset is held.
    assign src_ready = w_do_write && CLEAR_B;
    assign dst_valid = r_dst_valid;
    assign dst_data  = r_dst_data;
    assign PSEL      = r_psel;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

`ifdef SSP_HOST_STATS_EN
    logic [15:0] r_tx_count;
    logic [15:0] r_rx_count;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            r_tx_count <= '0;
            r_rx_count <= '0;
        end else begin
            if (r_state == WRITE) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
            if (r_state == READ_CAP) begin
                r_rx_count <= r_rx_count + 16'd1;
            end
        end
    end

    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;
`endif

endmodule

// File: tb/tb_ssp_host_ctrl.sv
// Self-checking bench for ssp_host_ctrl: transaction-timestamp reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ssp_host_ctrl;

    localparam int MAXO  = 4;
    localparam int DRAIN = 48;

    logic       PCLK      = 1'b0;
    logic       CLEAR_B   = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data  = 8'h00;
    logic       src_ready;
    logic       dst_valid;
    logic [7:0] dst_data;
    logic       dst_ready = 1'b0;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA    = 8'h00;
    logic       SSPTXINTR = 1'b0;
    logic       SSPRXINTR = 1'b0;
    logic       SSPOE_B   = 1'b0;
`ifdef SSP_HOST_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;
`endif

    always #5 PCLK = ~PCLK;

    ssp_host_ctrl #(
        .MAX_OUTSTANDING (MAXO),
        .DRAIN_CYCLES    (DRAIN)
    ) dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR),
        .SSPOE_B   (SSPOE_B)
`ifdef SSP_HOST_STATS_EN
        ,
        .tx_count  (tx_count),
        .rx_count  (rx_count)
`endif
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model: timestamps of scheduled bus events rather than a state machine.
    int         mFreeAt, mWrAt, mRdAt, mCapAt, mOut, mIdle, mTx, mRx;
    logic       mSlotValid;
    logic [7:0] mSlotData, mWrData;

    logic       expPsel, expPwrite, expSrcReady, expDstValid;
    logic       expPwdataValid, expDstDataValid;
    logic [7:0] expPwdata, expDstData;
    int         expTx, expRx;

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mFreeAt = 0; mWrAt = -1; mRdAt = -1; mCapAt = -1;
        mOut = 0; mIdle = 0; mTx = 0; mRx = 0;
        mSlotValid = 1'b0; mSlotData = 8'h00; mWrData = 8'h00;
        expPsel = 1'b0; expPwrite = 1'b0; expSrcReady = 1'b0; expDstValid = 1'b0;
        expPwdata = 8'h00; expDstData = 8'h00;
        expPwdataValid = 1'b1; expDstDataValid = 1'b1;
        expTx = 0; expRx = 0;
    endtask

    // Predicts this cycle's outputs from the rules, then advances to the next cycle.
    task automatic modelCycle();
        logic idleNow, slotFree, qual, expired, doRead, doWrite;
        expPsel         = (cyc == mWrAt) || (cyc == mRdAt);
        expPwrite       = (cyc == mWrAt);
        expPwdata       = mWrData;
        expPwdataValid  = (cyc == mWrAt);
        expDstValid     = mSlotValid;
        expDstData      = mSlotData;
        expDstDataValid = mSlotValid;
        expTx           = mTx;
        expRx           = mRx;

        idleNow  = (cyc >= mFreeAt);
        slotFree = !mSlotValid || dst_ready;
        qual     = idleNow && (mOut > 0) && SSPOE_B;
        expired  = (mIdle >= DRAIN) || (qual && (mIdle + 1 >= DRAIN));
        doRead   = idleNow && slotFree && (mOut > 0) && (SSPRXINTR || expired);
        doWrite  = idleNow && !doRead && src_valid && !SSPTXINTR && (mOut < MAXO);
        expSrcReady = doWrite;

        if (mSlotValid && dst_ready) mSlotValid = 1'b0;
        if (cyc == mCapAt) begin
            mSlotValid = 1'b1;
            mSlotData  = PRDATA;
        end
        if (cyc == mWrAt)  mTx++;
        if (cyc == mCapAt) mRx++;

        if (doRead) begin
            mRdAt = cyc + 1; mCapAt = cyc + 2; mFreeAt = cyc + 3;
            mOut--; mIdle = 0;
        end else if (doWrite) begin
            mWrAt = cyc + 1; mWrData = src_data; mFreeAt = cyc + 2;
            mOut++; mIdle = 0;
        end else if (qual) begin
            if (mIdle < DRAIN) mIdle++;
        end else if (idleNow && mOut == 0) begin
            mIdle = 0;
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic dr,
                                 input logic tx, input logic rx, input logic oe,
                                 input logic [7:0] prd);
        @(posedge PCLK);
        #1;
        cyc++;
        src_valid = sv; src_data = sd; dst_ready = dr;
        SSPTXINTR = tx; SSPRXINTR = rx; SSPOE_B = oe; PRDATA = prd;
        modelCycle();
    endtask

    task automatic checkOutput();
        checkValue("src_ready", int'(src_ready), int'(expSrcReady));
        checkValue("PSEL", int'(PSEL), int'(expPsel));
        checkValue("PWRITE", int'(PWRITE), int'(expPwrite));
        checkValue("dst_valid", int'(dst_valid), int'(expDstValid));
        if (expPwdataValid)  checkValue("PWDATA", int'(PWDATA), int'(expPwdata));
        if (expDstDataValid) checkValue("dst_data", int'(dst_data), int'(expDstData));
`ifdef SSP_HOST_STATS_EN
        checkValue("tx_count", int'(tx_count), expTx & 16'hFFFF);
        checkValue("rx_count", int'(rx_count), expRx & 16'hFFFF);
`endif
    endtask

    always @(negedge PCLK) checkOutput();

    task automatic doReset();
        src_valid = 1'b0; src_data = 8'h00; dst_ready = 1'b0;
        SSPTXINTR = 1'b0; SSPRXINTR = 1'b0; SSPOE_B = 1'b0; PRDATA = 8'h00;
        CLEAR_B = 1'b0;
        modelReset();
        #1;
        checkValue("rst_PSEL", int'(PSEL), 0);
        checkValue("rst_PWRITE", int'(PWRITE), 0);
        checkValue("rst_PWDATA", int'(PWDATA), 0);
        checkValue("rst_src_ready", int'(src_ready), 0);
        checkValue("rst_dst_valid", int'(dst_valid), 0);
        checkValue("rst_dst_data", int'(dst_data), 0);
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        CLEAR_B = 1'b1;
    endtask

    task automatic idleCycle(input logic oe);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, oe, 8'hEE);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent, writes, reads, idleSeen;
        logic found;
        int pSrc[4] = '{60, 90, 30, 80};
        int pRx[4]  = '{10, 0, 30, 5};
        int pDr[4]  = '{70, 90, 30, 20};
        int pTx[4]  = '{15, 0, 20, 10};
        int pOe[4]  = '{80, 95, 50, 100};

        doReset();

        $display("[TB] single write 0xA5");
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 checkValue("a5_src_ready", int'(src_ready), 1);
        idleCycle(1'b0);
        #1;
        checkValue("a5_PSEL", int'(PSEL), 1);
        checkValue("a5_PWRITE", int'(PWRITE), 1);
        checkValue("a5_PWDATA", int'(PWDATA), 8'hA5);

        $display("[TB] six bytes back-to-back");
        doReset();
        sent = 0; writes = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(sent < 6, 8'(16 + sent), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            if (src_ready) sent++;
            if (PSEL && PWRITE) writes++;
        end
        checkValue("b2b_accepted", sent, 4);
        checkValue("b2b_writes", writes, 4);
        checkValue("b2b_ready_low", int'(src_ready), 0);

        $display("[TB] rx interrupt beats pending write");
        doReset();
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        idleCycle(1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        #1 checkValue("rx_win_src_ready", int'(src_ready), 0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        #1;
        checkValue("rx_win_PSEL", int'(PSEL), 1);
        checkValue("rx_win_PWRITE", int'(PWRITE), 0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
        #1 checkValue("rx_win_cap_dst_valid", int'(dst_valid), 0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        #1;
        checkValue("rx_win_dst_valid", int'(dst_valid), 1);
        checkValue("rx_win_dst_data", int'(dst_data), 8'h3C);
        checkValue("rx_win_write_ready", int'(src_ready), 1);
        idleCycle(1'b0);
        #1;
        checkValue("rx_win_wr_PSEL", int'(PSEL), 1);
        checkValue("rx_win_wr_PWRITE", int'(PWRITE), 1);
        checkValue("rx_win_wr_PWDATA", int'(PWDATA), 8'h77);

        $display("[TB] drain timer");
        doReset();
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idleCycle(1'b1);
        idleSeen = 0; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            idleCycle(1'b1);
            #1;
            if (PSEL && !PWRITE) found = 1'b1;
            else idleSeen++;
        end
        checkValue("drain_idle_cycles", idleSeen, DRAIN);

        $display("[TB] consumer backpressure");
        doReset();
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
            #1;
            if (PSEL && !PWRITE) reads++;
        end
        checkValue("bp_reads_blocked", reads, 1);
        checkValue("bp_dst_held", int'(dst_valid), 1);
        checkValue("bp_dst_data", int'(dst_data), 8'h41);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h42);
            #1;
            if (PSEL && !PWRITE) reads++;
        end
        checkValue("bp_reads_resumed", reads, 1);

        $display("[TB] reset during write strobe");
        doReset();
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idleCycle(1'b0);
        #1 checkValue("mid_rst_PSEL_before", int'(PSEL), 1);
        doReset();

        $display("[TB] randomized traffic");
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                applyStimulus($urandom_range(0, 99) < pSrc[ph],
                              8'($urandom_range(0, 255)),
                              $urandom_range(0, 99) < pDr[ph],
                              $urandom_range(0, 99) < pTx[ph],
                              $urandom_range(0, 99) < pRx[ph],
                              $urandom_range(0, 99) < pOe[ph],
                              8'($urandom_range(0, 255)));
            end
        end

        @(posedge PCLK);
        @(negedge PCLK);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
